// File: rtl/ipv_reducer_mc_pkg.sv
// Shared limits, count-width helper and parameter legality check for the IPV reducer.
package ipv_red_pkg;

  localparam int unsigned IPV_RED_MAX_K     = 16;
  localparam int unsigned IPV_RED_MAX_CH    = 8;
  localparam int unsigned IPV_RED_MAX_STALL = 4;

  // Bits needed to hold a ones count of 0..k.
  function automatic int unsigned ipv_red_cw(input int unsigned k);
    return 32'($clog2(k + 1));
  endfunction

  function automatic bit ipv_red_params_ok(input int unsigned k,
                                           input int unsigned ch,
                                           input int unsigned stall);
    return (k >= 2) && (k <= IPV_RED_MAX_K) &&
           (ch >= 1) && (ch <= IPV_RED_MAX_CH) &&
           (stall >= 1) && (stall <= IPV_RED_MAX_STALL);
  endfunction

endpackage

// File: rtl/ipv_reducer_mc_if.sv
// Beat-in / vector-out bundle of the IPV reducer; cnt_out exists only with IPV_RED_POPCNT_EN.
interface ipv_reducer_mc_if #(
  parameter int unsigned K  = 4,
  parameter int unsigned CH = 2
) ();

  logic                in_valid;
  logic [CH-1:0]       ipv_in;
  logic                flush;
  logic [CH*K-1:0]     vov;
  logic                out_valid;
`ifdef IPV_RED_POPCNT_EN
  localparam int unsigned CW = ipv_red_pkg::ipv_red_cw(K);
  logic [CH*CW-1:0]    cnt_out;
`endif

  modport master (
    output in_valid, ipv_in, flush,
    input  vov, out_valid
`ifdef IPV_RED_POPCNT_EN
    , input cnt_out
`endif
  );

  modport slave (
    input  in_valid, ipv_in, flush,
    output vov, out_valid
`ifdef IPV_RED_POPCNT_EN
    , output cnt_out
`endif
  );

endinterface

// File: rtl/ipv_reducer_mc_lane.sv
// One lane's thermometer accumulator; with IPV_RED_POPCNT_EN it also reports the ones count.
module ipv_red_lane #(
  parameter int unsigned K  = 4
`ifdef IPV_RED_POPCNT_EN
  , parameter int unsigned CW = 3
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         beat_i,
  input  logic         first_i,
  input  logic         flush_i,
  input  logic         bit_i,
  output logic [K-1:0] acc_nxt_c_o
`ifdef IPV_RED_POPCNT_EN
  , output logic [CW-1:0] cnt_c_o
`endif
);

  logic [K-1:0] acc_q, acc_d, upd;

  // Value the accumulator takes if this cycle's bit is accepted.
  always_comb begin
    upd   = acc_q;
    acc_d = acc_q;
    if (first_i)    upd = {bit_i, {(K-1){1'b0}}};
    else if (bit_i) upd = {1'b1, acc_q[K-1:1]};
    if (flush_i)     acc_d = '0;
    else if (beat_i) acc_d = upd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc_nxt_c_o = upd;
`ifdef IPV_RED_POPCNT_EN
  assign cnt_c_o = CW'($countones(upd));
`endif

endmodule

// File: rtl/ipv_reducer_mc.sv
// Multi-lane IPV reducer: shared group counter, completion detect, STALL-deep output pipeline.
// Optional per-lane ones count on cnt_out when IPV_RED_POPCNT_EN is defined.
module ipv_reducer_mc
  import ipv_red_pkg::*;
#(
  parameter int unsigned K     = 4,
  parameter int unsigned CH    = 2,
  parameter int unsigned STALL = 2
) (
  input logic           clk,
  input logic           rst_n,
  ipv_reducer_mc_if.slave bus
);

  localparam int unsigned GW = $clog2(K);
  localparam int unsigned VW = CH * K;

  if (!ipv_red_params_ok(K, CH, STALL)) begin : g_bad_params
    $error("ipv_reducer_mc: illegal K/CH/STALL combination");
  end

  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          beat, first, last, done;
  logic [VW-1:0] upd_c, vov_d;
  logic [STALL-1:0] vld_q;
  logic [VW-1:0]    vov_q [STALL];

  assign beat  = bus.in_valid & ~bus.flush;
  assign first = (gcnt_q == '0);
  assign last  = (gcnt_q == GW'(K - 1));
  assign done  = beat & last;
  assign vov_d = done ? upd_c : '0;

  always_comb begin
    gcnt_d = gcnt_q;
    if (bus.flush)   gcnt_d = '0;
    else if (beat)   gcnt_d = last ? '0 : gcnt_q + GW'(1);
  end

`ifdef IPV_RED_POPCNT_EN
  localparam int unsigned CW = ipv_red_cw(K);
  logic [CH*CW-1:0] cnt_c, cnt_d;
  logic [CH*CW-1:0] cnt_q [STALL];
  assign cnt_d = done ? cnt_c : '0;
`endif

  for (genvar c = 0; c < CH; c++) begin : g_lane
    ipv_red_lane #(
      .K (K)
`ifdef IPV_RED_POPCNT_EN
      , .CW(CW)
`endif
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .beat_i     (beat),
      .first_i    (first),
      .flush_i    (bus.flush),
      .bit_i      (bus.ipv_in[c]),
      .acc_nxt_c_o(upd_c[c*K +: K])
`ifdef IPV_RED_POPCNT_EN
      , .cnt_c_o  (cnt_c[c*CW +: CW])
`endif
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) gcnt_q <= '0;
    else        gcnt_q <= gcnt_d;
  end

  // Valid and data advance together; idle slots carry zero data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int s = 0; s < int'(STALL); s++) begin
        vov_q[s] <= '0;
`ifdef IPV_RED_POPCNT_EN
        cnt_q[s] <= '0;
`endif
      end
    end else begin
      vld_q[0] <= done;
      vov_q[0] <= vov_d;
`ifdef IPV_RED_POPCNT_EN
      cnt_q[0] <= cnt_d;
`endif
      for (int s = 1; s < int'(STALL); s++) begin
        vld_q[s] <= vld_q[s-1];
        vov_q[s] <= vov_q[s-1];
`ifdef IPV_RED_POPCNT_EN
        cnt_q[s] <= cnt_q[s-1];
`endif
      end
    end
  end

  assign bus.out_valid = vld_q[STALL-1];
  assign bus.vov       = vov_q[STALL-1];
`ifdef IPV_RED_POPCNT_EN
  assign bus.cnt_out   = cnt_q[STALL-1];
`endif

endmodule
